intc_prio_arb: RTL and testbench

INTC_PRIO_ARB -- requirements
Module: intc_prio_arb

---
 rtl/intc_prio_arb.sv | 180 ++++++++++++++++++
 tb/tb_intc_prio_arb.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intc_prio_arb.sv
// intc_prio_arb -- scanning priority arbiter for an interrupt controller.
//
// Scans the pending sources GRP at a time. Over one full pass of NG groups it
// keeps the highest eligible priority level and its index, with ties going to
// the lowest index. A pass that finds a winner presents it to the CPU. The
// request is held until the CPU acknowledges it, or until the source stops
// being eligible. An acknowledge drives a one-cycle, one-hot pulse back to the
// capture stage.
//
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset
//   in_irq_i        pending requests, one bit per source
//   rg_ipr_i        4-bit priority level per source (0 = disabled)
//   cpu_imask_i     CPU mask level; a source is eligible only if level > mask
//   cpu_ack_i       single-cycle CPU acknowledge (honoured only while requesting)
//   cp_intreq_o     interrupt request to the CPU
//   cp_level_o      level of the presented request
//   cp_vec_o        vector of the presented request (VEC_BASE + index, mod 256)
//   cp_intack_o     one-hot acknowledge to the capture stage
//   stat_clr_i      (INTC_ARB_STAT_EN only) clears the acknowledge counter
//   stat_ack_cnt_o  (INTC_ARB_STAT_EN only) saturating acknowledge count
//
// Optional feature: define INTC_ARB_STAT_EN to add the acknowledge counter.
module intc_prio_arb #(
  parameter int INT_DW   = 192,
  parameter int GRP      = 8,
  parameter int VEC_BASE = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INT_DW-1:0] in_irq_i,
  input  logic [4*INT_DW-1:0] rg_ipr_i,
  input  logic [3:0]        cpu_imask_i,
  input  logic              cpu_ack_i,
  output logic              cp_intreq_o,
  output logic [3:0]        cp_level_o,
  output logic [7:0]        cp_vec_o,
  output logic [INT_DW-1:0] cp_intack_o
`ifdef INTC_ARB_STAT_EN
  ,
  input  logic              stat_clr_i,
  output logic [15:0]       stat_ack_cnt_o
`endif
);

  localparam int NG    = INT_DW / GRP;
  localparam int IDX_W = (INT_DW > 1) ? $clog2(INT_DW) : 1;
  localparam int G_W   = (NG > 1) ? $clog2(NG) : 1;
  localparam logic [G_W-1:0] G_LAST = G_W'(NG - 1);

  typedef enum logic [1:0] {S_SCAN, S_REQ, S_ACK} state_t;

  state_t             r_state, w_state_nxt;
  logic [G_W-1:0]     r_grp, w_grp_nxt;
  logic [3:0]         r_best_lvl, w_best_lvl_nxt;
  logic [IDX_W-1:0]   r_best_idx, w_best_idx_nxt;

  logic [3:0]         w_scan_lvl;
  logic [IDX_W-1:0]   w_scan_idx;
  logic [IDX_W-1:0]   w_src;
  logic [3:0]         w_lvl;

  logic               w_req_nxt;
  logic [3:0]         w_level_nxt;
  logic [7:0]         w_vec_nxt;
  logic [INT_DW-1:0]  w_ack_vec;

  // One group per cycle. The running best restarts from level 0 on group 0,
  // so a stale winner from the previous pass can never carry over. The strict
  // '>' compare is what keeps the lowest index when levels tie.
  always_comb begin
    w_scan_lvl = (r_grp == '0) ? 4'd0 : r_best_lvl;
    w_scan_idx = (r_grp == '0) ? '0 : r_best_idx;
    w_src      = '0;
    w_lvl      = '0;
    for (int j = 0; j < GRP; j++) begin
      w_src = IDX_W'(int'(r_grp) * GRP + j);
      w_lvl = rg_ipr_i[{w_src, 2'b00} +: 4];
      if (in_irq_i[w_src] && (w_lvl > cpu_imask_i) && (w_lvl > w_scan_lvl)) begin
        w_scan_lvl = w_lvl;
        w_scan_idx = w_src;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_grp_nxt      = r_grp;
    w_best_lvl_nxt = r_best_lvl;
    w_best_idx_nxt = r_best_idx;
    w_req_nxt      = 1'b0;
    w_level_nxt    = cp_level_o;
    w_vec_nxt      = cp_vec_o;
    w_ack_vec      = '0;
    case (r_state)
      S_SCAN: begin
        w_best_lvl_nxt = w_scan_lvl;
        w_best_idx_nxt = w_scan_idx;
        if (r_grp == G_LAST) begin
          w_grp_nxt = '0;
          if (w_scan_lvl != 4'd0) begin
            w_state_nxt = S_REQ;
            w_req_nxt   = 1'b1;
            w_level_nxt = w_scan_lvl;
            w_vec_nxt   = 8'(VEC_BASE) + 8'(w_scan_idx);
          end
        end else begin
          w_grp_nxt = r_grp + 1'b1;
        end
      end
      S_REQ: begin
        // An acknowledge wins over a simultaneous withdrawal.
        if (cpu_ack_i) begin
          w_state_nxt           = S_ACK;
          w_ack_vec[r_best_idx] = 1'b1;
        end else if (!in_irq_i[r_best_idx] || (cpu_imask_i >= r_best_lvl)) begin
          w_state_nxt = S_SCAN;
          w_grp_nxt   = '0;
        end else begin
          w_req_nxt = 1'b1;
        end
      end
      S_ACK: begin
        w_state_nxt = S_SCAN;
        w_grp_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_SCAN;
        w_grp_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_SCAN;
    else        r_state <= w_state_nxt;
  end

  // Scan bookkeeping and registered CPU-side outputs. The level and vector
  // are captured once at the end of a pass and held for the whole request,
  // so priority register writes during REQ do not disturb them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grp       <= '0;
      r_best_lvl  <= '0;
      r_best_idx  <= '0;
      cp_intreq_o <= 1'b0;
      cp_level_o  <= '0;
      cp_vec_o    <= '0;
      cp_intack_o <= '0;
    end else begin
      r_grp       <= w_grp_nxt;
      r_best_lvl  <= w_best_lvl_nxt;
      r_best_idx  <= w_best_idx_nxt;
      cp_intreq_o <= w_req_nxt;
      cp_level_o  <= w_level_nxt;
      cp_vec_o    <= w_vec_nxt;
      cp_intack_o <= w_ack_vec;
    end
  end

`ifdef INTC_ARB_STAT_EN
  logic [15:0] r_ack_cnt;

  // Clear has priority over the increment; the count saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack_cnt <= '0;
    end else if (stat_clr_i) begin
      r_ack_cnt <= '0;
    end else if ((r_state == S_ACK) && (r_ack_cnt != 16'hFFFF)) begin
      r_ack_cnt <= r_ack_cnt + 16'd1;
    end
  end

  assign stat_ack_cnt_o = r_ack_cnt;
`endif

endmodule

// File: tb/tb_intc_prio_arb.sv
module tb_intc_prio_arb;

  localparam int INT_DW   = 192;
  localparam int GRP      = 8;
  localparam int VEC_BASE = 64;
  localparam int NG       = INT_DW / GRP;
  localparam int LAT      = 2 * NG + 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [INT_DW-1:0]   in_irq_i = '0;
  logic [4*INT_DW-1:0] rg_ipr_i = '0;
  logic [3:0]          cpu_imask_i = '0;
  logic                cpu_ack_i = 1'b0;
  logic                cp_intreq_o;
  logic [3:0]          cp_level_o;
  logic [7:0]          cp_vec_o;
  logic [INT_DW-1:0]   cp_intack_o;
`ifdef INTC_ARB_STAT_EN
  logic                stat_clr_i = 1'b0;
  logic [15:0]         stat_ack_cnt_o;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  intc_prio_arb #(.INT_DW(INT_DW), .GRP(GRP), .VEC_BASE(VEC_BASE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_irq_i    (in_irq_i),
    .rg_ipr_i    (rg_ipr_i),
    .cpu_imask_i (cpu_imask_i),
    .cpu_ack_i   (cpu_ack_i),
    .cp_intreq_o (cp_intreq_o),
    .cp_level_o  (cp_level_o),
    .cp_vec_o    (cp_vec_o),
    .cp_intack_o (cp_intack_o)
`ifdef INTC_ARB_STAT_EN
    ,
    .stat_clr_i     (stat_clr_i),
    .stat_ack_cnt_o (stat_ack_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    cpu_ack_i   = 1'b0;
    rst_n       = 1'b0;
    in_irq_i    = '0;
    rg_ipr_i    = '0;
    cpu_imask_i = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_src(input int k, input int lvl);
    in_irq_i[k]       = 1'b1;
    rg_ipr_i[4*k +: 4] = 4'(lvl);
  endtask

  task automatic wait_req(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (cp_intreq_o) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_ack();
    cpu_ack_i = 1'b1;
    tick();
    cpu_ack_i = 1'b0;
  endtask

  // Reference: global maximum eligible level over all sources, lowest index on ties.
  function automatic void model(output int lvl, output int idx);
    int l;
    lvl = 0;
    idx = 0;
    for (int k = 0; k < INT_DW; k++) begin
      l = int'(rg_ipr_i[4*k +: 4]);
      if (in_irq_i[k] && l > int'(cpu_imask_i) && l > lvl) begin
        lvl = l;
        idx = k;
      end
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_chk++; if (cp_intreq_o !== 1'b0) begin n_fail++; $display("FAIL reset_intreq: got %0d expected 0", cp_intreq_o); end
    n_chk++; if (cp_level_o !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", cp_level_o); end
    n_chk++; if (cp_vec_o !== 8'd0) begin n_fail++; $display("FAIL reset_vec: got %0d expected 0", cp_vec_o); end
    n_chk++; if (cp_intack_o !== '0) begin n_fail++; $display("FAIL reset_intack: got %h expected 0", cp_intack_o); end
    apply_reset();
  endtask

  task automatic test_single();
    bit got;
    logic [INT_DW-1:0] exp_ack;
    apply_reset();
    set_src(5, 3);
    wait_req(LAT, got);
    n_chk++; if (got !== 1'b1) begin n_fail++; $display("FAIL single_req: got %0d expected 1", got); end
    n_chk++; if (cp_vec_o !== 8'd69) begin n_fail++; $display("FAIL single_vec: got %0d expected 69", cp_vec_o); end
    n_chk++; if (cp_level_o !== 4'd3) begin n_fail++; $display("FAIL single_level: got %0d expected 3", cp_level_o); end
    pulse_ack();
    exp_ack = '0;
    exp_ack[5] = 1'b1;
    n_chk++; if (cp_intack_o !== exp_ack) begin n_fail++; $display("FAIL single_ack: got %h expected %h", cp_intack_o, exp_ack); end
    n_chk++; if (cp_intreq_o !== 1'b0) begin n_fail++; $display("FAIL single_req_in_ack: got %0d expected 0", cp_intreq_o); end
    in_irq_i[5] = 1'b0;
    tick();
    n_chk++; if (cp_intack_o !== '0) begin n_fail++; $display("FAIL single_ack_width: got %h expected 0", cp_intack_o); end
  endtask

  task automatic test_priority();
    bit got;
    apply_reset();
    set_src(10, 7);
    set_src(150, 12);
    wait_req(LAT, got);
    n_chk++; if (got !== 1'b1) begin n_fail++; $display("FAIL prio_req: got %0d expected 1", got); end
    n_chk++; if (cp_vec_o !== 8'd214) begin n_fail++; $display("FAIL prio_vec: got %0d expected 214", cp_vec_o); end
    n_chk++; if (cp_level_o !== 4'd12) begin n_fail++; $display("FAIL prio_level: got %0d expected 12", cp_level_o); end
    // A priority write mid-request must not move the presented level/vector.
    rg_ipr_i[4*150 +: 4] = 4'd2;
    tick();
    n_chk++; if (cp_level_o !== 4'd12) begin n_fail++; $display("FAIL prio_level_hold: got %0d expected 12", cp_level_o); end
    pulse_ack();
    n_chk++; if (cp_intack_o[150] !== 1'b1) begin n_fail++; $display("FAIL prio_ack150: got %0d expected 1", cp_intack_o[150]); end
    in_irq_i[150] = 1'b0;
    wait_req(LAT, got);
    n_chk++; if (got !== 1'b1) begin n_fail++; $display("FAIL prio_req2: got %0d expected 1", got); end
    n_chk++; if (cp_vec_o !== 8'd74) begin n_fail++; $display("FAIL prio_vec2: got %0d expected 74", cp_vec_o); end
    n_chk++; if (cp_level_o !== 4'd7) begin n_fail++; $display("FAIL prio_level2: got %0d expected 7", cp_level_o); end
  endtask

  task automatic test_tie();
    bit got;
    apply_reset();
    set_src(20, 9);
    set_src(100, 9);
    set_src(30, 0);
    wait_req(LAT, got);
    n_chk++; if (got !== 1'b1) begin n_fail++; $display("FAIL tie_req: got %0d expected 1", got); end
    n_chk++; if (cp_vec_o !== 8'd84) begin n_fail++; $display("FAIL tie_vec: got %0d expected 84", cp_vec_o); end
    pulse_ack();
    in_irq_i[20]  = 1'b0;
    in_irq_i[100] = 1'b0;
    wait_req(100, got);
    n_chk++; if (got !== 1'b0) begin n_fail++; $display("FAIL level0_never: got %0d expected 0", got); end
  endtask

  task automatic test_mask();
    bit got;
    bit bad_ack;
    apply_reset();
    set_src(3, 9);
    cpu_imask_i = 4'd9;
    wait_req(100, got);
    n_chk++; if (got !== 1'b0) begin n_fail++; $display("FAIL mask_block: got %0d expected 0", got); end
    cpu_imask_i = 4'd8;
    wait_req(LAT, got);
    n_chk++; if (got !== 1'b1) begin n_fail++; $display("FAIL mask_pass: got %0d expected 1", got); end
    n_chk++; if (cp_vec_o !== 8'd67) begin n_fail++; $display("FAIL mask_vec: got %0d expected 67", cp_vec_o); end
    cpu_imask_i = 4'd9;
    tick();
    n_chk++; if (cp_intreq_o !== 1'b0) begin n_fail++; $display("FAIL withdraw_req: got %0d expected 0", cp_intreq_o); end
    bad_ack = 1'b0;
    for (int i = 0; i < 2 * NG; i++) begin
      if (cp_intack_o !== '0 || cp_intreq_o !== 1'b0) bad_ack = 1'b1;
      tick();
    end
    n_chk++; if (bad_ack !== 1'b0) begin n_fail++; $display("FAIL withdraw_quiet: got %0d expected 0", bad_ack); end
  endtask

  task automatic test_reset_in_req();
    bit got;
    bit bad_ack;
    apply_reset();
    set_src(40, 5);
    wait_req(LAT, got);
    n_chk++; if (got !== 1'b1) begin n_fail++; $display("FAIL rreq_req: got %0d expected 1", got); end
    #3;
    rst_n = 1'b0;
    #1;
    n_chk++; if (cp_intreq_o !== 1'b0) begin n_fail++; $display("FAIL rreq_async: got %0d expected 0", cp_intreq_o); end
    tick();
    rst_n     = 1'b1;
    cpu_ack_i = 1'b1;
    bad_ack   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cp_intack_o !== '0 || cp_intreq_o !== 1'b0) bad_ack = 1'b1;
    end
    cpu_ack_i = 1'b0;
    n_chk++; if (bad_ack !== 1'b0) begin n_fail++; $display("FAIL ack_in_scan: got %0d expected 0", bad_ack); end
    wait_req(LAT, got);
    n_chk++; if (got !== 1'b1 || cp_vec_o !== 8'd104) begin n_fail++; $display("FAIL rreq_rescan: got req %0d vec %0d expected 1 104", got, cp_vec_o); end
  endtask

  task automatic test_random();
    bit got;
    int lvl, idx;
    logic [INT_DW-1:0] exp_ack;
    for (int t = 0; t < 24; t++) begin
      apply_reset();
      for (int k = 0; k < INT_DW; k++) begin
        in_irq_i[k]        = ($urandom_range(0, 7) == 0);
        rg_ipr_i[4*k +: 4] = 4'($urandom_range(0, 15));
      end
      cpu_imask_i = 4'($urandom_range(0, (t % 4 == 3) ? 15 : 7));
      model(lvl, idx);
      wait_req(LAT + 1, got);
      if (lvl == 0) begin
        n_chk++; if (got !== 1'b0) begin n_fail++; $display("FAIL rand_none t%0d: got req %0d expected 0", t, got); end
      end else begin
        n_chk++;
        if (got !== 1'b1 || cp_level_o !== 4'(lvl) || cp_vec_o !== 8'(VEC_BASE + idx)) begin
          n_fail++;
          $display("FAIL rand_req t%0d: got req %0d lvl %0d vec %0d expected 1 %0d %0d",
                   t, got, cp_level_o, cp_vec_o, lvl, (VEC_BASE + idx) % 256);
        end
        pulse_ack();
        exp_ack = '0;
        exp_ack[idx] = 1'b1;
        n_chk++; if (cp_intack_o !== exp_ack) begin n_fail++; $display("FAIL rand_ack t%0d: got %h expected %h", t, cp_intack_o, exp_ack); end
      end
    end
  endtask

`ifdef INTC_ARB_STAT_EN
  task automatic test_stat();
    bit got;
    apply_reset();
    n_chk++; if (stat_ack_cnt_o !== 16'd0) begin n_fail++; $display("FAIL stat_reset: got %0d expected 0", stat_ack_cnt_o); end
    set_src(7, 4);
    for (int i = 0; i < 3; i++) begin
      wait_req(LAT, got);
      pulse_ack();
      tick();
    end
    n_chk++; if (stat_ack_cnt_o !== 16'd3) begin n_fail++; $display("FAIL stat_count: got %0d expected 3", stat_ack_cnt_o); end
    wait_req(LAT, got);
    pulse_ack();
    stat_clr_i = 1'b1;
    tick();
    stat_clr_i = 1'b0;
    n_chk++; if (stat_ack_cnt_o !== 16'd0) begin n_fail++; $display("FAIL stat_clr: got %0d expected 0", stat_ack_cnt_o); end
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_single();
    test_priority();
    test_tie();
    test_mask();
    test_reset_in_req();
    test_random();
`ifdef INTC_ARB_STAT_EN
    test_stat();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
